// File: rtl/fb_plot_sink_pkg.sv
// fb_plot_sink_pkg: shared constants, FSM state type and the framebuffer
// address helper used by the plot sink, its RAM and its testbench.
package fb_plot_sink_pkg;

    localparam int SCR_W    = 160;
    localparam int SCR_H    = 120;
    localparam int FB_DEPTH = 19200;
    localparam int ADDR_W   = 15;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COL_W    = 3;
    localparam int CNT_W    = 15;

    localparam logic [X_W-1:0]    X_LAST   = 8'd159;
    localparam logic [Y_W-1:0]    Y_LAST   = 7'd119;
    localparam logic [ADDR_W-1:0] CLR_LAST = 15'd19199;
    localparam logic [CNT_W-1:0]  CNT_MAX  = 15'd32767;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Linear address y*160 + x built from shifts: 160 = 128 + 32.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] yy;
        logic [ADDR_W-1:0] xx;
        yy = {8'd0, y};
        xx = {7'd0, x};
        return (yy << 7) + (yy << 5) + xx;
    endfunction

endpackage

// File: rtl/fb_plot_sink_if.sv
// fb_plot_sink_if: plot port (vga_*), ready, scan request/stream and the
// plot counter. slave = the sink, master = the client driving plots/scans.
interface fb_plot_sink_if;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        ready;
    logic        scan_start;
    logic        scan_done;
    logic        scan_valid;
    logic [7:0]  scan_x;
    logic [6:0]  scan_y;
    logic [2:0]  scan_colour;
    logic [14:0] plot_count;

    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot, scan_start,
        output ready, scan_done, scan_valid, scan_x, scan_y, scan_colour, plot_count
    );

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot, scan_start,
        input  ready, scan_done, scan_valid, scan_x, scan_y, scan_colour, plot_count
    );
endinterface

// File: rtl/fb_ram.sv
// fb_ram: 19200 x 3 simple dual-port RAM. One write port, one synchronous
// read port with 1-cycle latency; a same-cycle read of the written address
// returns the old contents. rdata resets to 0.
// Ports: clk, rst_n (sync, active-low, read register only), we/waddr/wdata,
// re/raddr, rdata.
module fb_ram
    import fb_plot_sink_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [COL_W-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [COL_W-1:0]  rdata
);

    logic [COL_W-1:0] mem [0:FB_DEPTH-1];
    logic [COL_W-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register; the non-blocking write above lands after this read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= 3'd0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fb_plot_sink.sv
// fb_plot_sink: 160x120x3 framebuffer sink. After reset it clears every
// pixel to CLEAR_COLOUR, then accepts single-cycle plots and, on request,
// streams the whole buffer column-major (x outer, y inner).
// Ports: clk, rst_n (sync, active-low), bus (fb_plot_sink_if.slave).
module fb_plot_sink
    import fb_plot_sink_pkg::*;
#(
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
)
(
    input  logic           clk,
    input  logic           rst_n,
    fb_plot_sink_if.slave  bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [X_W-1:0]    sx_q, sx_d;
    logic [Y_W-1:0]    sy_q, sy_d;
    logic              last_q, last_d;
    logic              ready_q, ready_d;
    logic              scan_valid_q, scan_valid_d;
    logic              scan_done_q, scan_done_d;
    logic [X_W-1:0]    scan_x_q, scan_x_d;
    logic [Y_W-1:0]    scan_y_q, scan_y_d;
    logic [CNT_W-1:0]  plot_count_q, plot_count_d;

    logic              plot_ok;
    logic              clearing;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [COL_W-1:0]  ram_wdata;
    logic              ram_re;
    logic [COL_W-1:0]  ram_rdata;

    // Plot acceptance, plot counter and RAM write-port steering.
    always_comb begin
        plot_ok  = ready_q && bus.vga_plot && (bus.vga_x <= X_LAST) && (bus.vga_y <= Y_LAST);
        clearing = (state_q == ST_CLEAR);
        if (plot_ok && (plot_count_q != CNT_MAX)) begin
            plot_count_d = plot_count_q + 15'd1;
        end else begin
            plot_count_d = plot_count_q;
        end
        // A plot landing on the reset edge must not corrupt the restarted clear.
        ram_we = rst_n && (clearing || plot_ok);
        if (clearing) begin
            ram_waddr = clr_addr_q;
            ram_wdata = CLEAR_COLOUR;
        end else begin
            ram_waddr = fb_addr(bus.vga_x, bus.vga_y);
            ram_wdata = bus.vga_colour;
        end
    end

    // FSM next state, scan address walk and registered scan outputs.
    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        last_d       = last_q;
        ready_d      = ready_q;
        scan_done_d  = scan_done_q;
        scan_x_d     = scan_x_q;
        scan_y_d     = scan_y_q;
        scan_valid_d = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (clr_addr_q == CLR_LAST) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = 15'd0;
                    ready_d    = 1'b1;
                end else begin
                    clr_addr_d = clr_addr_q + 15'd1;
                end
            end
            ST_IDLE: begin
                if (bus.scan_start) begin
                    state_d = ST_SCAN;
                    sx_d    = 8'd0;
                    sy_d    = 7'd0;
                    last_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!bus.scan_start) begin
                    state_d = ST_IDLE;
                end else if (last_q) begin
                    // Final beat is on the outputs this cycle; done follows it.
                    state_d     = ST_DONE;
                    scan_done_d = 1'b1;
                end else begin
                    scan_valid_d = 1'b1;
                    scan_x_d     = sx_q;
                    scan_y_d     = sy_q;
                    if (sy_q == Y_LAST) begin
                        sy_d = 7'd0;
                        if (sx_q == X_LAST) begin
                            last_d = 1'b1;
                        end else begin
                            sx_d = sx_q + 8'd1;
                        end
                    end else begin
                        sy_d = sy_q + 7'd1;
                    end
                end
            end
            ST_DONE: begin
                if (!bus.scan_start) begin
                    state_d     = ST_IDLE;
                    scan_done_d = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = 15'd0;
                ready_d    = 1'b0;
            end
        endcase
        ram_re = scan_valid_d;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            clr_addr_q   <= 15'd0;
            sx_q         <= 8'd0;
            sy_q         <= 7'd0;
            last_q       <= 1'b0;
            ready_q      <= 1'b0;
            scan_valid_q <= 1'b0;
            scan_done_q  <= 1'b0;
            scan_x_q     <= 8'd0;
            scan_y_q     <= 7'd0;
            plot_count_q <= 15'd0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            last_q       <= last_d;
            ready_q      <= ready_d;
            scan_valid_q <= scan_valid_d;
            scan_done_q  <= scan_done_d;
            scan_x_q     <= scan_x_d;
            scan_y_q     <= scan_y_d;
            plot_count_q <= plot_count_d;
        end
    end

    fb_ram u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (fb_addr(sx_q, sy_q)),
        .rdata (ram_rdata)
    );

    assign bus.ready       = ready_q;
    assign bus.scan_valid  = scan_valid_q;
    assign bus.scan_done   = scan_done_q;
    assign bus.scan_x      = scan_x_q;
    assign bus.scan_y      = scan_y_q;
    assign bus.scan_colour = ram_rdata;
    assign bus.plot_count  = plot_count_q;

endmodule

// File: tb/tb_fb_plot_sink.sv
// tb_fb_plot_sink: drives plots and scans into fb_plot_sink and checks every
// scan beat against a behavioural framebuffer model (array + plot counter).
module tb_fb_plot_sink;
    import fb_plot_sink_pkg::*;

    logic clk;
    logic rst_n;
    fb_plot_sink_if bus ();

    fb_plot_sink #(.CLEAR_COLOUR(3'b000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [2:0] ref_fb [0:FB_DEPTH-1];
    int         ref_count;
    bit         model_ready;

    // Injected plot aimed at the very cycle the scan reads its address.
    bit inj_armed;
    int inj_beat, inj_x, inj_y, inj_c;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int a = 0; a < FB_DEPTH; a++) ref_fb[a] = 3'b000;
        ref_count   = 0;
        model_ready = 1'b0;
    endfunction

    function automatic void model_plot(input int x, input int y, input int c);
        if (model_ready && x < SCR_W && y < SCR_H) begin
            ref_fb[y * SCR_W + x] = c[2:0];
            if (ref_count < 32767) ref_count++;
        end
    endfunction

    task automatic plot_once(input int x, input int y, input int c);
        bus.vga_x      = x[7:0];
        bus.vga_y      = y[6:0];
        bus.vga_colour = c[2:0];
        bus.vga_plot   = 1'b1;
        @(negedge clk);
        bus.vga_plot = 1'b0;
        model_plot(x, y, c);
    endtask

    task automatic reset_and_clear(input bit scan_held);
        logic [31:0] beat;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_ready", bus.ready, 0);
        check_val("rst_valid", bus.scan_valid, 0);
        check_val("rst_done", bus.scan_done, 0);
        check_val("rst_x", bus.scan_x, 0);
        check_val("rst_y", bus.scan_y, 0);
        check_val("rst_colour", bus.scan_colour, 0);
        check_val("rst_count", bus.plot_count, 0);
        rst_n = 1'b1;
        for (int i = 1; i <= FB_DEPTH; i++) begin
            // In-range plots during the clear must be dropped.
            bus.vga_x      = 8'd20;
            bus.vga_y      = 7'd20;
            bus.vga_colour = 3'b111;
            bus.vga_plot   = (i <= 5);
            @(negedge clk);
            check_val("clear_ready", bus.ready, (i >= FB_DEPTH) ? 1 : 0);
        end
        bus.vga_plot = 1'b0;
        model_ready  = 1'b1;
        check_val("clear_count", bus.plot_count, 0);
        if (scan_held) begin
            @(negedge clk);
            check_val("held_idle_valid", bus.scan_valid, 0);
            @(negedge clk);
            check_val("held_first_valid", bus.scan_valid, 1);
            beat = {14'd0, bus.scan_x, bus.scan_y, bus.scan_colour};
            check_val("held_first_beat", beat, 32'd0);
            bus.scan_start = 1'b0;
            @(negedge clk);
            check_val("held_abort_valid", bus.scan_valid, 0);
        end
    endtask

    // Scan the buffer, dropping scan_start after stop_after beats (19200 = full).
    task automatic run_scan(input int stop_after, input bit rand_plots);
        int lat, idx, ex, ey, px, py, pc;
        bit pend;
        logic [7:0]  ex8;
        logic [6:0]  ey7;
        logic [31:0] obs, exp;
        pend = 1'b0;
        bus.scan_start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.scan_valid && lat < 20);
        check_val("first_beat_latency", lat, 2);
        idx = 0;
        while (idx < stop_after) begin
            if (idx > 0) @(negedge clk);
            check_val("scan_valid", bus.scan_valid, 1);
            ex  = idx / SCR_H;
            ey  = idx % SCR_H;
            ex8 = ex[7:0];
            ey7 = ey[6:0];
            obs = {14'd0, bus.scan_x, bus.scan_y, bus.scan_colour};
            exp = {14'd0, ex8, ey7, ref_fb[ey * SCR_W + ex]};
            check_val("beat", obs, exp);
            // A plot driven in the read cycle only becomes visible afterwards.
            if (pend) begin
                model_plot(px, py, pc);
                pend = 1'b0;
            end
            idx++;
            bus.vga_plot = 1'b0;
            if (idx < stop_after) begin
                if (inj_armed && idx == inj_beat) begin
                    px = inj_x; py = inj_y; pc = inj_c;
                    inj_armed = 1'b0;
                    pend = 1'b1;
                end else if (rand_plots && $urandom_range(0, 15) == 0) begin
                    px = $urandom_range(0, 170);
                    py = $urandom_range(0, 127);
                    pc = $urandom_range(0, 7);
                    if (px == inj_x && py == inj_y) px = 4;
                    pend = 1'b1;
                end
                if (pend) begin
                    bus.vga_x      = px[7:0];
                    bus.vga_y      = py[6:0];
                    bus.vga_colour = pc[2:0];
                    bus.vga_plot   = 1'b1;
                end
            end
        end
        if (stop_after >= FB_DEPTH) begin
            check_val("done_not_early", bus.scan_done, 0);
            @(negedge clk);
            check_val("done_rise", bus.scan_done, 1);
            check_val("done_valid_low", bus.scan_valid, 0);
            repeat (3) begin
                @(negedge clk);
                check_val("done_hold", bus.scan_done, 1);
            end
            bus.scan_start = 1'b0;
            @(negedge clk);
            check_val("done_clear", bus.scan_done, 0);
        end else begin
            bus.scan_start = 1'b0;
            @(negedge clk);
            check_val("abort_valid", bus.scan_valid, 0);
            repeat (4) begin
                @(negedge clk);
                check_val("abort_no_done", bus.scan_done, 0);
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.vga_x      = 8'd0;
        bus.vga_y      = 7'd0;
        bus.vga_colour = 3'd0;
        bus.vga_plot   = 1'b0;
        bus.scan_start = 1'b0;
        inj_armed      = 1'b0;
        inj_beat       = 2 * SCR_H + 3;
        inj_x          = 2;
        inj_y          = 3;
        inj_c          = 7;

        reset_and_clear(1'b0);

        plot_once(0, 0, 5);
        plot_once(159, 119, 3);
        plot_once(37, 64, 6);
        plot_once(160, 5, 7);
        plot_once(5, 120, 7);
        plot_once(255, 127, 1);
        check_val("plot_count_3", bus.plot_count, 3);

        run_scan(500, 1'b0);

        inj_armed = 1'b1;
        run_scan(FB_DEPTH, 1'b1);
        check_val("inj_consumed", inj_armed, 0);
        check_val("plot_count_after_scan", bus.plot_count, ref_count);

        run_scan(300, 1'b0);

        // Reset in the middle of a scan with scan_start held throughout.
        bus.scan_start = 1'b1;
        repeat (100) @(negedge clk);
        reset_and_clear(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
